// File: rtl/el2_ifu_ic_mem_arb.sv
// Shares the I-cache array's single read/write port between fetch reads, 8-beat
// line fills and debug array reads/writes (fixed priority fill > dbg wr > dbg rd > fetch).
module el2_ifu_ic_mem_arb (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_fetch_req,
  input  logic [30:0] io_fetch_addr,
  output logic        io_fetch_gnt,
  input  logic        io_fill_req,
  input  logic [30:0] io_fill_addr,
  input  logic [1:0]  io_fill_way,
  input  logic        io_fill_data_vld,
  input  logic [70:0] io_fill_data,
  output logic        io_fill_beat_ack,
  output logic        io_fill_done,
  input  logic        io_dbg_rd_req,
  input  logic        io_dbg_wr_req,
  input  logic [8:0]  io_dbg_addr,
  input  logic [1:0]  io_dbg_way,
  input  logic        io_dbg_tag_array,
  input  logic [70:0] io_dbg_wr_data,
  output logic [70:0] io_dbg_rd_data,
  output logic        io_dbg_done,
  output logic [30:0] io_ic_rw_addr,
  output logic        io_ic_rd_en,
  output logic [1:0]  io_ic_wr_en,
  output logic [70:0] io_ic_wr_data_0,
  output logic [70:0] io_ic_wr_data_1,
  output logic        io_ic_debug_rd_en,
  output logic        io_ic_debug_wr_en,
  output logic [8:0]  io_ic_debug_addr,
  output logic [1:0]  io_ic_debug_way,
  output logic        io_ic_debug_tag_array,
  output logic [70:0] io_ic_debug_wr_data,
  input  logic [70:0] io_ic_debug_rd_data
);

  typedef enum logic [1:0] {IDLE, FILL, DBG_CAP, DBG_DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  beat, beat_nxt;
  logic [25:0] base_q;
  logic [1:0]  way_q;
  logic [70:0] dbg_data_q;
  logic        fill_done_q;
  logic        fill_start, dbg_wr_start, dbg_rd_start, beat_wr, port_free;
  logic        wr_fire, dbg_fire;
  logic        unused_fill_lo;

  assign unused_fill_lo = ^io_fill_addr[4:0];

  // The requester keeps io_fill_req high through the done cycle, so it is masked
  // there to avoid re-starting the line it just finished.
  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    fill_start   = 1'b0;
    dbg_wr_start = 1'b0;
    dbg_rd_start = 1'b0;
    beat_wr      = 1'b0;
    port_free    = 1'b0;
    case (state)
      IDLE: begin
        if (io_fill_req && !fill_done_q) begin
          fill_start = 1'b1;
          beat_nxt   = 3'd0;
          state_nxt  = FILL;
        end else if (io_dbg_wr_req) begin
          dbg_wr_start = 1'b1;
          state_nxt    = DBG_DONE;
        end else if (io_dbg_rd_req) begin
          dbg_rd_start = 1'b1;
          state_nxt    = DBG_CAP;
        end else begin
          port_free = 1'b1;
        end
      end
      FILL: begin
        if (io_fill_data_vld) begin
          beat_wr  = 1'b1;
          beat_nxt = beat + 3'd1;
          if (beat == 3'd7) state_nxt = IDLE;
        end else begin
          port_free = 1'b1;
        end
      end
      DBG_CAP:  state_nxt = DBG_DONE;
      DBG_DONE: begin
        port_free = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      beat        <= 3'd0;
      base_q      <= 26'd0;
      way_q       <= 2'b00;
      dbg_data_q  <= 71'd0;
      fill_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat        <= beat_nxt;
      fill_done_q <= beat_wr && (beat == 3'd7);
      if (fill_start) begin
        base_q <= io_fill_addr[30:5];
        way_q  <= io_fill_way;
      end
      if (state == DBG_CAP) dbg_data_q <= io_ic_debug_rd_data;
    end
  end

  // Nothing touches the array while reset is asserted, even mid-operation.
  assign wr_fire  = beat_wr & ~reset;
  assign dbg_fire = (dbg_rd_start | dbg_wr_start) & ~reset;

  assign io_fetch_gnt     = io_fetch_req & port_free & ~reset;
  assign io_ic_rd_en      = io_fetch_gnt;
  assign io_fill_beat_ack = wr_fire;
  assign io_fill_done     = fill_done_q & ~reset;
  assign io_dbg_done      = (state == DBG_DONE) & ~reset;
  assign io_dbg_rd_data   = dbg_data_q;

  assign io_ic_wr_en     = wr_fire ? way_q : 2'b00;
  assign io_ic_rw_addr   = wr_fire ? {base_q, beat, 2'b00} : io_fetch_addr;
  assign io_ic_wr_data_0 = wr_fire ? io_fill_data : 71'd0;
  assign io_ic_wr_data_1 = wr_fire ? io_fill_data : 71'd0;

  assign io_ic_debug_rd_en     = dbg_rd_start & ~reset;
  assign io_ic_debug_wr_en     = dbg_wr_start & ~reset;
  assign io_ic_debug_addr      = dbg_fire ? io_dbg_addr : 9'd0;
  assign io_ic_debug_way       = dbg_fire ? io_dbg_way : 2'b00;
  assign io_ic_debug_tag_array = dbg_fire & io_dbg_tag_array;
  assign io_ic_debug_wr_data   = io_ic_debug_wr_en ? io_dbg_wr_data : 71'd0;

endmodule

// File: tb/tb_el2_ifu_ic_mem_arb.sv
// Directed scenario tasks plus a randomized run checked against a transaction-level model.
module tb_el2_ifu_ic_mem_arb;
  logic        clock = 1'b0;
  logic        reset;
  logic        io_fetch_req;
  logic [30:0] io_fetch_addr;
  logic        io_fetch_gnt;
  logic        io_fill_req;
  logic [30:0] io_fill_addr;
  logic [1:0]  io_fill_way;
  logic        io_fill_data_vld;
  logic [70:0] io_fill_data;
  logic        io_fill_beat_ack, io_fill_done;
  logic        io_dbg_rd_req, io_dbg_wr_req;
  logic [8:0]  io_dbg_addr;
  logic [1:0]  io_dbg_way;
  logic        io_dbg_tag_array;
  logic [70:0] io_dbg_wr_data, io_dbg_rd_data;
  logic        io_dbg_done;
  logic [30:0] io_ic_rw_addr;
  logic        io_ic_rd_en;
  logic [1:0]  io_ic_wr_en;
  logic [70:0] io_ic_wr_data_0, io_ic_wr_data_1;
  logic        io_ic_debug_rd_en, io_ic_debug_wr_en;
  logic [8:0]  io_ic_debug_addr;
  logic [1:0]  io_ic_debug_way;
  logic        io_ic_debug_tag_array;
  logic [70:0] io_ic_debug_wr_data, io_ic_debug_rd_data;

  int n_vec = 0;
  int n_err = 0;

  el2_ifu_ic_mem_arb dut (
    .clock(clock), .reset(reset),
    .io_fetch_req(io_fetch_req), .io_fetch_addr(io_fetch_addr), .io_fetch_gnt(io_fetch_gnt),
    .io_fill_req(io_fill_req), .io_fill_addr(io_fill_addr), .io_fill_way(io_fill_way),
    .io_fill_data_vld(io_fill_data_vld), .io_fill_data(io_fill_data),
    .io_fill_beat_ack(io_fill_beat_ack), .io_fill_done(io_fill_done),
    .io_dbg_rd_req(io_dbg_rd_req), .io_dbg_wr_req(io_dbg_wr_req), .io_dbg_addr(io_dbg_addr),
    .io_dbg_way(io_dbg_way), .io_dbg_tag_array(io_dbg_tag_array), .io_dbg_wr_data(io_dbg_wr_data),
    .io_dbg_rd_data(io_dbg_rd_data), .io_dbg_done(io_dbg_done),
    .io_ic_rw_addr(io_ic_rw_addr), .io_ic_rd_en(io_ic_rd_en), .io_ic_wr_en(io_ic_wr_en),
    .io_ic_wr_data_0(io_ic_wr_data_0), .io_ic_wr_data_1(io_ic_wr_data_1),
    .io_ic_debug_rd_en(io_ic_debug_rd_en), .io_ic_debug_wr_en(io_ic_debug_wr_en),
    .io_ic_debug_addr(io_ic_debug_addr), .io_ic_debug_way(io_ic_debug_way),
    .io_ic_debug_tag_array(io_ic_debug_tag_array), .io_ic_debug_wr_data(io_ic_debug_wr_data),
    .io_ic_debug_rd_data(io_ic_debug_rd_data)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    io_fetch_req = 0; io_fetch_addr = '0; io_fill_req = 0; io_fill_addr = '0; io_fill_way = '0;
    io_fill_data_vld = 0; io_fill_data = '0; io_dbg_rd_req = 0; io_dbg_wr_req = 0;
    io_dbg_addr = '0; io_dbg_way = '0; io_dbg_tag_array = 0; io_dbg_wr_data = '0;
    io_ic_debug_rd_data = '0;
  endtask

  // ---------------- reference model: counts of outstanding work ----------------
  int          m_fill_left, m_next_beat, m_dbg_left;
  logic [25:0] m_base;
  logic [1:0]  m_way;
  logic        m_done_pend;
  logic [70:0] m_dbg_data;
  logic        m_fs, m_ws, m_rs, m_bt;
  logic [335:0] exp_v, act_v;

  task automatic model_reset;
    m_fill_left = 0; m_next_beat = 0; m_dbg_left = 0; m_base = '0; m_way = '0;
    m_done_pend = 0; m_dbg_data = '0;
  endtask

  task automatic model_eval;
    logic idle, free, on, gnt, dop;
    logic [30:0] addr;
    idle = (m_fill_left == 0) && (m_dbg_left == 0);
    m_fs = idle && io_fill_req && !m_done_pend;
    m_ws = idle && !m_fs && io_dbg_wr_req;
    m_rs = idle && !m_fs && !m_ws && io_dbg_rd_req;
    m_bt = (m_fill_left > 0) && io_fill_data_vld;
    free = (idle && !m_fs && !m_ws && !m_rs) || ((m_fill_left > 0) && !io_fill_data_vld)
           || (m_dbg_left == 1);
    on   = !reset;
    gnt  = on && io_fetch_req && free;
    dop  = on && (m_ws || m_rs);
    addr = (on && m_bt) ? {m_base, 3'(m_next_beat), 2'b00} : io_fetch_addr;
    exp_v = {gnt, gnt, on && m_bt, on && m_done_pend, on && (m_dbg_left == 1),
             (on && m_bt) ? m_way : 2'b00, addr,
             (on && m_bt) ? io_fill_data : 71'd0, (on && m_bt) ? io_fill_data : 71'd0,
             on && m_rs, on && m_ws, dop ? io_dbg_addr : 9'd0, dop ? io_dbg_way : 2'b00,
             dop && io_dbg_tag_array, (on && m_ws) ? io_dbg_wr_data : 71'd0, m_dbg_data};
  endtask

  task automatic model_tick;
    logic nd;
    if (reset) begin
      model_reset();
    end else begin
      nd = 0;
      if (m_fs) begin
        m_fill_left = 8; m_next_beat = 0; m_base = io_fill_addr[30:5]; m_way = io_fill_way;
      end
      if (m_bt) begin
        m_next_beat++; m_fill_left--;
        if (m_fill_left == 0) nd = 1;
      end
      if (m_dbg_left == 2) m_dbg_data = io_ic_debug_rd_data;
      if (m_dbg_left > 0) m_dbg_left--;
      if (m_ws) m_dbg_left = 1;
      if (m_rs) m_dbg_left = 2;
      m_done_pend = nd;
    end
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset;
    clear_inputs();
    reset = 1; step(); step();
    reset = 0;
    @(negedge clock);
    n_vec++;
    if ({io_fetch_gnt, io_fill_beat_ack, io_fill_done, io_dbg_done, io_ic_rd_en, io_ic_wr_en,
         io_ic_debug_rd_en, io_ic_debug_wr_en} !== 9'd0) begin
      n_err++; $display("FAIL reset_strobes act=%b exp=0", {io_fetch_gnt, io_fill_beat_ack,
        io_fill_done, io_dbg_done, io_ic_rd_en, io_ic_wr_en, io_ic_debug_rd_en, io_ic_debug_wr_en});
    end
    n_vec++;
    if (io_dbg_rd_data !== 71'd0) begin
      n_err++; $display("FAIL reset_rd_data act=%h exp=0", io_dbg_rd_data);
    end
    step();
  endtask

  task automatic test_fetch;
    io_fetch_req = 1; io_fetch_addr = 31'h1234;
    @(negedge clock);
    n_vec++;
    if ({io_fetch_gnt, io_ic_rd_en, io_ic_rw_addr} !== {1'b1, 1'b1, 31'h1234}) begin
      n_err++; $display("FAIL fetch_idle act=%b/%b/%h exp=1/1/1234", io_fetch_gnt, io_ic_rd_en,
                        io_ic_rw_addr);
    end
    step();
    io_fetch_req = 0; step();
  endtask

  task automatic test_fill_burst;
    io_fill_req = 1; io_fill_addr = 31'h40_0020; io_fill_way = 2'b10; io_fetch_req = 1;
    @(negedge clock);
    n_vec++;
    if ({io_ic_wr_en, io_fetch_gnt, io_fill_beat_ack} !== 4'b0) begin
      n_err++; $display("FAIL fill_entry act=%b exp=0000", {io_ic_wr_en, io_fetch_gnt, io_fill_beat_ack});
    end
    step();
    for (int i = 0; i < 8; i++) begin
      io_fill_data_vld = 1; io_fill_data = 71'h100 + 71'(i);
      @(negedge clock);
      n_vec++;
      if ({io_ic_wr_en, io_ic_rw_addr, io_fill_beat_ack, io_fetch_gnt, io_ic_wr_data_1}
          !== {2'b10, 31'h40_0020 + 31'(4 * i), 1'b1, 1'b0, 71'h100 + 71'(i)}) begin
        n_err++; $display("FAIL fill_beat%0d act=%b/%h/%b/%b exp=10/%h/1/0", i, io_ic_wr_en,
                          io_ic_rw_addr, io_fill_beat_ack, io_fetch_gnt, 31'h40_0020 + 31'(4 * i));
      end
      step();
    end
    io_fill_data_vld = 0;
    @(negedge clock);
    n_vec++;
    if (io_fill_done !== 1'b1) begin
      n_err++; $display("FAIL fill_done act=%b exp=1", io_fill_done);
    end
    step();
    io_fill_req = 0; io_fetch_req = 0;
    @(negedge clock);
    n_vec++;
    if (io_fill_done !== 1'b0) begin
      n_err++; $display("FAIL fill_done_pulse act=%b exp=0", io_fill_done);
    end
    step();
  endtask

  task automatic test_fill_gaps;
    int beats = 0;
    io_fill_req = 1; io_fill_addr = 31'h7_1000; io_fill_way = 2'b01; io_fetch_req = 1;
    io_fetch_addr = 31'h55;
    step();
    for (int c = 0; c < 64 && beats < 8; c++) begin
      io_fill_data_vld = ($urandom_range(0, 1) == 1);
      @(negedge clock);
      n_vec++;
      if ({io_fetch_gnt, io_ic_wr_en != 2'b00} !== {!io_fill_data_vld, io_fill_data_vld}) begin
        n_err++; $display("FAIL fill_gap c%0d gnt=%b wr_en=%b vld=%b", c, io_fetch_gnt,
                          io_ic_wr_en, io_fill_data_vld);
      end
      if (io_fill_data_vld) beats++;
      step();
    end
    io_fill_data_vld = 0; io_fetch_req = 0;
    @(negedge clock);
    n_vec++;
    if (io_fill_done !== 1'b1) begin
      n_err++; $display("FAIL fill_gap_done act=%b exp=1", io_fill_done);
    end
    step();
    io_fill_req = 0; step();
  endtask

  task automatic test_dbg_read;
    io_dbg_rd_req = 1; io_dbg_addr = 9'h55; io_dbg_way = 2'b01; io_dbg_tag_array = 1;
    @(negedge clock);
    n_vec++;
    if ({io_ic_debug_rd_en, io_ic_debug_addr, io_ic_debug_way, io_ic_debug_tag_array, io_dbg_done}
        !== {1'b1, 9'h55, 2'b01, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL dbg_rd_T act=%b/%h exp=1/055", io_ic_debug_rd_en, io_ic_debug_addr);
    end
    step();
    io_ic_debug_rd_data = 71'h5A5;
    @(negedge clock);
    n_vec++;
    if ({io_dbg_done, io_ic_debug_rd_en} !== 2'b00) begin
      n_err++; $display("FAIL dbg_rd_T1 done=%b rd_en=%b exp=0/0", io_dbg_done, io_ic_debug_rd_en);
    end
    step();
    io_ic_debug_rd_data = 71'h3FF;
    @(negedge clock);
    n_vec++;
    if ({io_dbg_done, io_dbg_rd_data} !== {1'b1, 71'h5A5}) begin
      n_err++; $display("FAIL dbg_rd_T2 done=%b data=%h exp=1/5a5", io_dbg_done, io_dbg_rd_data);
    end
    step();
    io_dbg_rd_req = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_vec++;
      if ({io_dbg_done, io_dbg_rd_data} !== {1'b0, 71'h5A5}) begin
        n_err++; $display("FAIL dbg_rd_hold%0d done=%b data=%h exp=0/5a5", i, io_dbg_done,
                          io_dbg_rd_data);
      end
      step();
    end
  endtask

  task automatic test_priority;
    io_fill_req = 1; io_fill_addr = 31'h2000; io_fill_way = 2'b01;
    io_dbg_wr_req = 1; io_dbg_addr = 9'h1A2; io_dbg_way = 2'b10; io_dbg_wr_data = 71'h77;
    io_fetch_req = 1; io_fetch_addr = 31'h99;
    @(negedge clock);
    n_vec++;
    if ({io_ic_debug_wr_en, io_fetch_gnt, io_ic_wr_en} !== 4'b0) begin
      n_err++; $display("FAIL prio_entry act=%b exp=0000", {io_ic_debug_wr_en, io_fetch_gnt, io_ic_wr_en});
    end
    step();
    io_fill_data_vld = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_vec++;
      if ({io_ic_debug_wr_en, io_ic_wr_en, io_fetch_gnt} !== {1'b0, 2'b01, 1'b0}) begin
        n_err++; $display("FAIL prio_beat%0d dwr=%b wr_en=%b gnt=%b exp=0/01/0", i,
                          io_ic_debug_wr_en, io_ic_wr_en, io_fetch_gnt);
      end
      step();
    end
    io_fill_data_vld = 0;
    @(negedge clock);
    n_vec++;
    if ({io_fill_done, io_ic_debug_wr_en, io_ic_debug_addr, io_ic_debug_wr_data, io_fetch_gnt}
        !== {1'b1, 1'b1, 9'h1A2, 71'h77, 1'b0}) begin
      n_err++; $display("FAIL prio_dwr done=%b dwr=%b addr=%h gnt=%b exp=1/1/1a2/0", io_fill_done,
                        io_ic_debug_wr_en, io_ic_debug_addr, io_fetch_gnt);
    end
    step();
    io_fill_req = 0;
    @(negedge clock);
    n_vec++;
    if ({io_dbg_done, io_fetch_gnt, io_ic_rw_addr} !== {1'b1, 1'b1, 31'h99}) begin
      n_err++; $display("FAIL prio_dbg_done done=%b gnt=%b addr=%h exp=1/1/99", io_dbg_done,
                        io_fetch_gnt, io_ic_rw_addr);
    end
    step();
    io_dbg_wr_req = 0; io_fetch_req = 0; step();
  endtask

  task automatic test_reset_mid_fill;
    io_fill_req = 1; io_fill_addr = 31'h1000; io_fill_way = 2'b01;
    step();
    io_fill_data_vld = 1;
    step(); step(); step();
    reset = 1;
    @(negedge clock);
    n_vec++;
    if ({io_ic_wr_en, io_fill_beat_ack} !== 3'b0) begin
      n_err++; $display("FAIL rst_beat3 wr_en=%b ack=%b exp=00/0", io_ic_wr_en, io_fill_beat_ack);
    end
    step();
    reset = 0; io_fill_data_vld = 0;
    @(negedge clock);
    n_vec++;
    if ({io_fill_done, io_ic_wr_en} !== 3'b0) begin
      n_err++; $display("FAIL rst_restart_entry done=%b wr_en=%b exp=0/00", io_fill_done, io_ic_wr_en);
    end
    step();
    io_fill_data_vld = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_vec++;
      if ({io_fill_beat_ack, io_ic_rw_addr} !== {1'b1, 31'h1000 + 31'(4 * i)}) begin
        n_err++; $display("FAIL rst_refill_beat%0d ack=%b addr=%h exp=1/%h", i, io_fill_beat_ack,
                          io_ic_rw_addr, 31'h1000 + 31'(4 * i));
      end
      step();
    end
    io_fill_data_vld = 0;
    @(negedge clock);
    n_vec++;
    if (io_fill_done !== 1'b1) begin
      n_err++; $display("FAIL rst_refill_done act=%b exp=1", io_fill_done);
    end
    step();
    io_fill_req = 0; step();
  endtask

  task automatic test_random;
    logic [95:0] r;
    logic saw_fill_done, saw_dbg_done;
    clear_inputs();
    reset = 1; step(); reset = 0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      io_fetch_req = $urandom_range(0, 1) == 1;
      io_fetch_addr = 31'($urandom);
      io_fill_data_vld = $urandom_range(0, 2) != 0;
      r = {$urandom, $urandom, $urandom}; io_fill_data = r[70:0];
      r = {$urandom, $urandom, $urandom}; io_ic_debug_rd_data = r[70:0];
      if (!io_fill_req && $urandom_range(0, 7) == 0) begin
        io_fill_req = 1; io_fill_addr = 31'($urandom); io_fill_way = 2'b01 << $urandom_range(0, 1);
      end
      if (!io_dbg_rd_req && !io_dbg_wr_req && $urandom_range(0, 5) == 0) begin
        io_dbg_rd_req = $urandom_range(0, 1) == 1;
        io_dbg_wr_req = !io_dbg_rd_req || ($urandom_range(0, 3) == 0);
        io_dbg_addr = 9'($urandom); io_dbg_way = 2'($urandom); io_dbg_tag_array = 1'($urandom);
        r = {$urandom, $urandom, $urandom}; io_dbg_wr_data = r[70:0];
      end
      @(negedge clock);
      model_eval();
      act_v = {io_fetch_gnt, io_ic_rd_en, io_fill_beat_ack, io_fill_done, io_dbg_done, io_ic_wr_en,
               io_ic_rw_addr, io_ic_wr_data_0, io_ic_wr_data_1, io_ic_debug_rd_en, io_ic_debug_wr_en,
               io_ic_debug_addr, io_ic_debug_way, io_ic_debug_tag_array, io_ic_debug_wr_data,
               io_dbg_rd_data};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++; $display("FAIL random_c%0d act=%h exp=%h", c, act_v, exp_v);
      end
      saw_fill_done = io_fill_done;
      saw_dbg_done = io_dbg_done;
      model_tick();
      step();
      if (saw_fill_done) io_fill_req = 0;
      if (saw_dbg_done) begin io_dbg_rd_req = 0; io_dbg_wr_req = 0; end
    end
    reset = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_fetch();
    test_fill_burst();
    test_fill_gaps();
    test_dbg_read();
    test_priority();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/el2_ifu_ic_mem_arb.md
# el2_ifu_ic_mem_arb

Access arbiter and sequencer in front of the I-cache data/tag array (`el2_ifu_ic_mem`). It shares the array's single read/write port between three requesters: fetch reads, miss-buffer line fills and debug (DMI) array reads/writes. It sequences an 8-beat fill burst with address generation and way-enable steering, and runs the two-cycle debug read capture. It sits between the IFU fetch/miss logic and the array.

## Interface
- Parameters: none (line = 64 B = 8 beats of 64 data + 7 ECC bits; fixed).
- `clock` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `io_fetch_req` in 1: fetch read request.
- `io_fetch_addr` in 31: fetch halfword address.
- `io_fetch_gnt` out 1: fetch read issued this cycle.
- `io_fill_req` in 1: start line fill (held until `io_fill_done`).
- `io_fill_addr` in 31: fill line address; bits [4:0] ignored.
- `io_fill_way` in 2: one-hot victim way.
- `io_fill_data_vld` in 1: fill beat data valid.
- `io_fill_data` in 71: beat data with ECC.
- `io_fill_beat_ack` out 1: beat written this cycle.
- `io_fill_done` out 1: one-cycle pulse after the 8th beat.
- `io_dbg_rd_req` / `io_dbg_wr_req` in 1 each: debug op requests (held until `io_dbg_done`).
- `io_dbg_addr` in 9; `io_dbg_way` in 2; `io_dbg_tag_array` in 1; `io_dbg_wr_data` in 71: debug op fields.
- `io_dbg_rd_data` out 71: captured debug read data.
- `io_dbg_done` out 1: one-cycle completion pulse.
- `io_ic_rw_addr` out 31; `io_ic_rd_en` out 1; `io_ic_wr_en` out 2; `io_ic_wr_data_0` / `io_ic_wr_data_1` out 71: array fetch/fill port.
- `io_ic_debug_rd_en` / `io_ic_debug_wr_en` out 1; `io_ic_debug_addr` out 9; `io_ic_debug_way` out 2; `io_ic_debug_tag_array` out 1; `io_ic_debug_wr_data` out 71: array debug port.
- `io_ic_debug_rd_data` in 71: array debug read data, valid the cycle after `io_ic_debug_rd_en`.

## Operation
- FSM states: IDLE, FILL, DBG_CAP, DBG_DONE. Registers: 3-bit beat counter, latched line base [30:5], latched way, 71-bit debug data register.
- Arbitration in IDLE, fixed priority: fill > debug write > debug read > fetch.
- IDLE + `io_fill_req`:
  - latch line base and way; beat = 0; go to FILL.
  - No array write in the entry cycle.
  - Fetch is not granted in the entry cycle.
- FILL:
  - `io_fill_data_vld`=1:
    - `io_ic_wr_en` = latched way.
    - `io_ic_rw_addr` = {base, beat, 2'b00}.
    - `io_ic_wr_data_0` = `io_ic_wr_data_1` = `io_fill_data`.
    - `io_fill_beat_ack`=1; beat += 1.
  - `io_fill_data_vld`=0: fetch may be granted (`io_ic_rw_addr` = `io_fetch_addr`).
  - Beat 7 acked: go to IDLE; `io_fill_done`=1 on the next cycle.
- IDLE + `io_dbg_wr_req`:
  - pulse `io_ic_debug_wr_en` with the debug fields; go to DBG_DONE.
  - If rd and wr requests are both high, the write wins.
- IDLE + `io_dbg_rd_req`: pulse `io_ic_debug_rd_en`; go to DBG_CAP.
- DBG_CAP: load the debug data register from `io_ic_debug_rd_data`; go to DBG_DONE.
- DBG_DONE: `io_dbg_done`=1; go to IDLE. No fill or debug start in this cycle; fetch may be granted.
- `io_dbg_rd_data` holds the last captured value until the next debug read capture.
- Fetch is granted only when the array port is free: IDLE with no fill/debug request, FILL with no beat, or DBG_DONE. `io_fetch_gnt` = `io_ic_rd_en` = `io_fetch_req` & free.
- Array outputs are zero whenever not driven for an op. `io_ic_rw_addr` defaults to `io_fetch_addr`.
- Requests arriving while the arbiter is busy wait; none is dropped.

## Timing
- Reset values:
  - state IDLE, beat 0.
  - `io_dbg_rd_data`=0.
  - All strobes and enables 0: `io_fetch_gnt`, `io_fill_beat_ack`, `io_fill_done`, `io_dbg_done`, `io_ic_rd_en`, `io_ic_wr_en`, `io_ic_debug_rd_en`, `io_ic_debug_wr_en`.
- Fetch grant is combinational, same cycle as the request.
- Fill:
  - Beat write and ack are in the same cycle as `io_fill_data_vld`.
  - Minimum fill = 1 entry cycle + 8 beat cycles + 1 done cycle.
- Debug read: enable at T, capture at T+1, `io_dbg_done` and valid data at T+2.
- Debug write: enable at T, `io_dbg_done` at T+1.
- Reset asserted mid-fill or mid-debug: abort immediately. No done pulse, beat counter cleared. A still-held request restarts from IDLE after reset.
- `io_fill_data_vld` outside FILL is ignored (no ack).

## Test plan
- Idle, `io_fetch_req`=1, addr 0x1234 -> same-cycle `io_fetch_gnt`=1, `io_ic_rd_en`=1, `io_ic_rw_addr`=0x1234.
- Fill with addr 0x40_0020, way 2'b10, 8 back-to-back vld beats -> `io_ic_wr_en`=2'b10 on beats 0..7, `io_ic_rw_addr` low 5 bits 0x00, 0x04, …, 0x1C, `io_fill_done` one cycle after the last beat.
- Fill with vld gaps while `io_fetch_req`=1 -> fetch granted only in gap cycles, never together with a beat write.
- Debug read: array returns 71'h5A5 at T+1 -> `io_dbg_done` at T+2, `io_dbg_rd_data`=71'h5A5 held afterwards.
- Simultaneous fill, debug write and fetch requests in IDLE -> fill completes first, then the debug write (`io_dbg_done` next cycle), fetch granted in the DBG_DONE cycle.
- Reset at fill beat 3 -> no `io_fill_done`. After reset with `io_fill_req` still held, refill restarts at beat 0.
